lcd_receiver: RTL
=================

LCD_RECEIVER -- requirements
Module: lcd_receiver

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameters (name, default, meaning) SHALL be as follows.
  BUSY_CYC, 40, busy cycles after a normal accepted transfer.
  CLR_CYC, 64, busy cycles after the clear command; legal values are 33 and above.
REQ-003 Ports (name, direction, width, meaning) SHALL be as follows.
  lcdclk  in  1  system clock.
  reset  in  1  synchronous, active-high reset.
  lcd_rs  in  1  register select: 0 = instruction, 1 = data.
  lcd_rw  in  1  1 = read cycle; read cycles are ignored.
  lcd_en  in  1  transfer strobe; asynchronous to lcdclk.
  lcd_data  in  8  bus byte.
  rd_addr  in  5  display RAM read address.
  rd_char  out  8  display RAM byte at rd_addr, registered.
  cursor_addr  out  5  current write address.
  display_on  out  1  display-enable flag.
  busy  out  1  high while the model is busy.
  err_busy  out  1  sticky flag: a transfer was dropped because busy was high.
  cmd_valid  out  1  one-cycle pulse per accepted transfer (trace).
  cmd_rs  out  1  lcd_rs of the accepted transfer (trace).
  cmd_byte  out  8  lcd_data of the accepted transfer (trace).

Function
REQ-004 lcd_en, lcd_rs, lcd_rw and lcd_data SHALL each pass through a 2-flop synchronizer.
REQ-005 A transfer SHALL be detected when synchronized lcd_en is 1 in one cycle and 0 in the next; the synchronized rs, rw and data sampled in that cycle form the transfer.
REQ-006 A transfer with rw=1 SHALL cause no state change and no cmd_valid pulse.
REQ-007 A write transfer detected while busy=1 SHALL be dropped and SHALL set err_busy.
REQ-008 Otherwise the transfer SHALL be accepted.
  - All state updates occur on the clock edge following detection.
  - cmd_valid pulses for exactly 1 cycle.
  - busy rises on that same edge.
REQ-009 The display RAM SHALL be 32 x 8. Write address 0-15 is line 1 and 16-31 is line 2.
REQ-010 A data write (rs=1) SHALL store the byte at RAM[cursor_addr], then step the cursor.
  - Step is +1 if the entry flag id=1, and -1 if id=0.
  - The cursor wraps 31->0 and 0->31.
REQ-011 Instructions (rs=0) SHALL be decoded by the highest set bit of the byte.
  - 0x00: no-op; accepted, so busy still rises.
  - 0x01, clear: RAM is filled with 0x20 one entry per cycle over 32 cycles; cursor=0; id=1; busy for CLR_CYC.
  - 0x02-0x03, home: cursor=0.
  - 0000_01xS, entry mode: id = bit1. The S bit is ignored.
  - 0000_1Dxx, display control: display_on = D.
  - 0001_SRxx with S=0: cursor +1 if R=1, else -1, with wrap. When S=1 there is no state change.
  - 001x_xxxx (function set) and 01xx_xxxx (CGRAM address): accepted, no state change.
  - 1AAA_AAAA, set DDRAM address: cursor = {A[6], A[3:0]}. For example 0xC5 gives 21.
REQ-012 Busy counter behaviour:
  - The counter loads BUSY_CYC, or CLR_CYC for clear, on acceptance.
  - It decrements every cycle.
  - busy = (counter != 0).
REQ-013 rd_char SHALL show RAM[rd_addr] 1 cycle after rd_addr is applied. A same-cycle write is visible on the following read.

Reset
REQ-014 Reset SHALL force the following values on the next edge, including mid-clear, which aborts the fill.
  - Outputs: cursor_addr=0, display_on=0, busy=0, err_busy=0, cmd_valid=0, cmd_rs=0, cmd_byte=0, rd_char=0.
  - Internal state: id=1, synchronizers=0.
REQ-015 Reset SHALL NOT initialize RAM contents; only clear initializes them.

Configuration
REQ-016 Macro LCD_RX_TRACE_EN SHALL control the trace outputs.
  - Defined: cmd_valid, cmd_rs and cmd_byte are driven as in REQ-008.
  - Undefined: all three are tied to 0 and their registers are omitted.
  - All other behaviour is identical in both cases.

Verification
REQ-017 The bench SHALL cover the following directed scenarios:
  - Reset, then write 0x38, 0x0C, 0x06, 0x01 with gaps >= CLR_CYC -> display_on=1, cursor_addr=0, all 32 rd_char reads = 0x20.
  - After init, write 0x80 then data "HI" (0x48, 0x49) -> RAM[0]=0x48, RAM[1]=0x49, cursor_addr=2.
  - Write 0xCF then 0x41, 0x42 -> RAM[31]=0x41, RAM[0]=0x42 (wrap), cursor_addr=1.
  - Write 0x04 (id=0), 0x80, then data 0x5A -> RAM[0]=0x5A, cursor_addr=31.
  - Write 0x41 only 5 cycles after a prior accepted write -> write dropped, err_busy=1, RAM unchanged.
  - Assert reset 10 cycles into a clear -> busy=0, cursor_addr=0; entries 10-31 keep prior contents.

Source files
------------

// File: rtl/lcd_receiver.sv
// lcd_receiver: HD44780-style write-bus receiver with a 32x8 display RAM, busy model and clear fill.
// Define LCD_RX_TRACE_EN to drive the cmd_valid/cmd_rs/cmd_byte trace outputs.
module lcd_receiver #(
  parameter int BUSY_CYC = 40,
  parameter int CLR_CYC  = 64
) (
  input  logic       lcdclk,
  input  logic       reset,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_en,
  input  logic [7:0] lcd_data,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_char,
  output logic [4:0] cursor_addr,
  output logic       display_on,
  output logic       busy,
  output logic       err_busy,
  output logic       cmd_valid,
  output logic       cmd_rs,
  output logic [7:0] cmd_byte
);
  // bus fields packed as {en, rs, rw, data}; p_q is the synchronized value one cycle back
  logic [10:0] s1_q, s2_q, p_q;
  logic [7:0]  ram [32];
  logic [7:0]  rd_q;
  logic [4:0]  cur_q, cur_d, fidx_q;
  logic [15:0] cnt_q, cnt_d;
  logic        id_q, id_d, disp_q, disp_d, err_q, err_d, fill_q;
  logic        det, acc, rs, is_clr;
  logic [7:0]  b;
  assign det         = p_q[10] & ~s2_q[10];
  assign rs          = p_q[9];
  assign b           = p_q[7:0];
  assign busy        = cnt_q != 16'd0;
  assign acc         = det & ~p_q[8] & ~busy;
  assign is_clr      = acc & ~rs & (b == 8'h01);
  assign rd_char     = rd_q;
  assign cursor_addr = cur_q;
  assign display_on  = disp_q;
  assign err_busy    = err_q;
  always_comb begin
    cur_d  = cur_q;
    id_d   = id_q;
    disp_d = disp_q;
    err_d  = err_q | (det & ~p_q[8] & busy);
    cnt_d  = busy ? cnt_q - 16'd1 : cnt_q;
    if (acc) begin
      cnt_d = is_clr ? 16'(CLR_CYC) : 16'(BUSY_CYC);
      if (rs) cur_d = id_q ? cur_q + 5'd1 : cur_q - 5'd1;
      else if (b[7]) cur_d = {b[6], b[3:0]};
      else if (b[6] | b[5]) cur_d = cur_q;
      else if (b[4]) cur_d = b[3] ? cur_q : (b[2] ? cur_q + 5'd1 : cur_q - 5'd1);
      else if (b[3]) disp_d = b[2];
      else if (b[2]) id_d = b[1];
      else if (b[1]) cur_d = '0;
      else if (b[0]) begin
        cur_d = '0;
        id_d  = 1'b1;
      end
    end
  end
  always_ff @(posedge lcdclk) begin
    if (reset) begin
      s1_q   <= '0;
      s2_q   <= '0;
      p_q    <= '0;
      cur_q  <= '0;
      id_q   <= 1'b1;
      disp_q <= 1'b0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
      fill_q <= 1'b0;
      fidx_q <= '0;
      rd_q   <= '0;
    end else begin
      s1_q   <= {lcd_en, lcd_rs, lcd_rw, lcd_data};
      s2_q   <= s1_q;
      p_q    <= s2_q;
      cur_q  <= cur_d;
      id_q   <= id_d;
      disp_q <= disp_d;
      err_q  <= err_d;
      cnt_q  <= cnt_d;
      fill_q <= is_clr | (fill_q & (fidx_q != 5'd31));
      fidx_q <= fill_q ? fidx_q + 5'd1 : '0;
      rd_q   <= ram[rd_addr];
    end
  end
  // RAM has no reset; CLR_CYC >= 33 guarantees the fill never overlaps a data write
  always_ff @(posedge lcdclk) begin
    if (!reset && fill_q) ram[fidx_q] <= 8'h20;
    else if (!reset && acc && rs) ram[cur_q] <= b;
  end
`ifdef LCD_RX_TRACE_EN
  logic       cv_q, crs_q;
  logic [7:0] cb_q;
  always_ff @(posedge lcdclk) begin
    if (reset) begin
      cv_q  <= 1'b0;
      crs_q <= 1'b0;
      cb_q  <= '0;
    end else begin
      cv_q <= acc;
      if (acc) begin
        crs_q <= rs;
        cb_q  <= b;
      end
    end
  end
  assign cmd_valid = cv_q;
  assign cmd_rs    = crs_q;
  assign cmd_byte  = cb_q;
`else
  assign cmd_valid = 1'b0;
  assign cmd_rs    = 1'b0;
  assign cmd_byte  = 8'h00;
`endif
endmodule
